// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multiport register file.
package regfile_pkg;

    typedef enum logic {INIT, RUN} rf_state_t;

    localparam int DW_DEFAULT    = 32;
    localparam int NREGS_DEFAULT = 16;

    localparam logic [31:0] EXT_IDLE_VAL = 32'd1;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: zeroes storage entries 0..NREGS-2 after reset or on request,
// then holds RUN until the next clear.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output rf_state_t     state,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 2);

    rf_state_t     state_nx;
    logic [AW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= (state_nx == RUN);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        clr_addr = cnt;
        case (state)
            INIT: begin
                clr_we = 1'b1;
                if (clr_req) begin
                    cnt_nx = '0;
                end else if (cnt == LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_nx = INIT;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = INIT;
        endcase
    end

endmodule

// File: rtl/regfile_multiport.sv
// NREGS x DW register file with NRD combinational read ports, one write port,
// PC alias on the top index, write-through bypass and mode-gated extended ports.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 4,
    parameter int NEXT  = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DW-1:0]           wdata,
    input  logic [DW-1:0]           pc_in,
    input  logic                    ext_en,
    input  logic [NRD-1:0][AW-1:0]  raddr,
    output logic [NRD-1:0][DW-1:0]  rdata,
    output logic                    ready,
    output logic                    wr_err
);

    localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

    rf_state_t     state;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_acc;

    // The PC index has no backing storage.
    logic [DW-1:0] mem [0:NREGS-2];

    regfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .state    (state),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The range check also rejects indices past NREGS-1 for non-power-of-two NREGS.
    assign wr_acc = (state == RUN) && we && !clr_req && (int'(waddr) < NREGS - 1);

    // Sweep and accepted writes are exclusive: one only in INIT, the other only in RUN.
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wr_acc)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_err <= 1'b0;
        else
            wr_err <= we && !wr_acc;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if (i >= NRD - NEXT && !ext_en)
                rdata[i] = DW'(EXT_IDLE_VAL);
            else if (raddr[i] == PC_IDX)
                rdata[i] = pc_in;
            else if (state == INIT)
                rdata[i] = '0;
            else if (wr_acc && waddr == raddr[i])
                rdata[i] = wdata;
            else if (int'(raddr[i]) >= NREGS - 1)
                rdata[i] = '0;
            else
                rdata[i] = mem[raddr[i]];
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: reset/sweep timing, directed vector table,
// clear and mid-sweep reset sequences, then random traffic against a model.
module tb_regfile_multiport;
    import regfile_pkg::*;

    localparam int DW = 32, NREGS = 16, NRD = 4, NEXT = 2, AW = 4;

    logic clk = 1'b0, rst_n = 1'b0, clr_req = 1'b0, we = 1'b0, ext_en = 1'b1;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0, pc_in = '0;
    logic [NRD-1:0][AW-1:0] raddr = '0;
    logic [NRD-1:0][DW-1:0] rdata;
    logic ready, wr_err;

    int nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    regfile_multiport #(.DW(DW), .NREGS(NREGS), .NRD(NRD), .NEXT(NEXT)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .we(we), .waddr(waddr),
        .wdata(wdata), .pc_in(pc_in), .ext_en(ext_en), .raddr(raddr),
        .rdata(rdata), .ready(ready), .wr_err(wr_err)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Directed vectors, applied back to back in RUN.
    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ext;
        logic [DW-1:0] pc;
        logic [AW-1:0] ra [NRD];
        logic [DW-1:0] er [NRD];
        logic          err;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ext, input logic [DW-1:0] pc,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [AW-1:0] r2, input logic [AW-1:0] r3,
                       input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                       input logic [DW-1:0] e2, input logic [DW-1:0] e3, input logic err);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.ext = ext; v.pc = pc;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
        v.er[0] = e0; v.er[1] = e1; v.er[2] = e2; v.er[3] = e3;
        v.err = err;
        tbl.push_back(v);
    endtask

    // Reference model: a countdown of edges left until RUN plus a plain array.
    logic [DW-1:0] m_mem [NREGS];
    int m_busy;

    function automatic logic m_accept();
        return we && m_busy == 0 && !clr_req && int'(waddr) < NREGS - 1;
    endfunction

    function automatic logic [DW-1:0] m_read(input int port, input logic [AW-1:0] ra);
        if (port >= NRD - NEXT && !ext_en) return 32'd1;
        if (int'(ra) == NREGS - 1)         return pc_in;
        if (m_busy > 0)                    return '0;
        if (m_accept() && waddr == ra)     return wdata;
        return m_mem[ra];
    endfunction

    task automatic m_clear();
        m_busy = NREGS - 1;
        for (int k = 0; k < NREGS; k++) m_mem[k] = '0;
    endtask

    initial begin
        logic exp_err;

        // Reset state
        #2;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_wr_err", 32'(wr_err), 0);
        #10 rst_n = 1'b1;
        pc_in = 32'h0000_0100;
        for (int k = 0; k < NREGS - 1; k++) begin
            chk("sweep_ready", 32'(ready), 0);
            chk("sweep_rd0", rdata[0], 0);
            @(posedge clk); #1;
        end
        chk("sweep_done_ready", 32'(ready), 1);

        //   we wa  wd            ext pc            ra0..3              exp rdata 0..3                                    err
        add(1, 3, 32'hDEADBEEF, 1, 32'h100, 3, 15, 0, 0,  32'hDEADBEEF, 32'h100, 0, 0, 0);
        add(0, 0, 32'h0,        1, 32'h100, 3, 15, 3, 3,  32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        add(1, 15, 32'h12345678, 1, 32'h100, 3, 15, 1, 2, 32'hDEADBEEF, 32'h100, 0, 0, 1);
        add(0, 0, 32'h0,        0, 32'h100, 3, 15, 3, 3,  32'hDEADBEEF, 32'h100, 1, 1, 0);
        add(0, 0, 32'h0,        0, 32'h200, 15, 15, 15, 15, 32'h200, 32'h200, 1, 1, 0);
        add(1, 7, 32'hA5A5A5A5, 1, 32'h200, 7, 7, 7, 3,   32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF, 0);
        add(1, 7, 32'h11111111, 1, 32'h300, 7, 3, 0, 15,  32'h11111111, 32'hDEADBEEF, 0, 32'h300, 0);
        add(0, 0, 32'h0,        1, 32'h300, 7, 7, 14, 15, 32'h11111111, 32'h11111111, 0, 32'h300, 0);
        add(1, 14, 32'hCAFEF00D, 0, 32'h300, 14, 3, 14, 7, 32'hCAFEF00D, 32'hDEADBEEF, 1, 1, 0);
        add(0, 0, 32'h0,        1, 32'h300, 14, 14, 3, 7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF, 32'h11111111, 0);
        add(1, 5, 32'h55,       1, 32'h300, 5, 0, 0, 0,   32'h55, 0, 0, 0, 0);

        foreach (tbl[n]) begin
            we = tbl[n].we; waddr = tbl[n].wa; wdata = tbl[n].wd;
            ext_en = tbl[n].ext; pc_in = tbl[n].pc;
            for (int p = 0; p < NRD; p++) raddr[p] = tbl[n].ra[p];
            #2;
            for (int p = 0; p < NRD; p++) chk($sformatf("tbl%0d_rd%0d", n, p), rdata[p], tbl[n].er[p]);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_wr_err", n), 32'(wr_err), 32'(tbl[n].err));
            chk($sformatf("tbl%0d_ready", n), 32'(ready), 1);
        end

        // Clear request with a write in the same cycle: write rejected, no bypass
        ext_en = 1'b1;
        we = 1'b1; waddr = 4'd5; wdata = 32'h77; clr_req = 1'b1;
        raddr[0] = 4'd5; raddr[1] = 4'd3;
        #2 chk("clr_no_bypass", rdata[0], 32'h55);
        @(posedge clk); #1;
        chk("clr_wr_err", 32'(wr_err), 1);
        chk("clr_ready", 32'(ready), 0);
        clr_req = 1'b0;
        for (int k = 0; k < NREGS - 1; k++) begin
            we = (k == 0); waddr = 4'd2; wdata = 32'h99;
            #2;
            chk("init_rd", rdata[1], 0);
            chk("init_ready", 32'(ready), 0);
            @(posedge clk); #1;
            if (k == 0) chk("init_wr_err", 32'(wr_err), 1);
        end
        we = 1'b0;
        chk("clr_done_ready", 32'(ready), 1);
        for (int b = 0; b < NREGS; b += NRD) begin
            for (int p = 0; p < NRD; p++) raddr[p] = AW'(b + p);
            #1;
            for (int p = 0; p < NRD; p++)
                chk($sformatf("post_clr_r%0d", b + p), rdata[p], (b + p == NREGS - 1) ? pc_in : 32'h0);
        end

        // Reset asserted mid-sweep at cnt=7
        @(posedge clk); #1;
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_wr_err", 32'(wr_err), 0);
        rst_n = 1'b1;
        for (int k = 0; k < NREGS - 1; k++) begin
            chk("resweep_ready", 32'(ready), 0);
            @(posedge clk); #1;
        end
        chk("resweep_done_ready", 32'(ready), 1);

        // Random traffic; storage is all zero and the block is in RUN here
        m_clear();
        m_busy = 0;
        for (int c = 0; c < 400; c++) begin
            we      = $urandom_range(0, 2) != 0;
            waddr   = AW'($urandom_range(0, NREGS - 1));
            wdata   = $urandom;
            pc_in   = $urandom;
            clr_req = $urandom_range(0, 39) == 0;
            ext_en  = $urandom_range(0, 3) != 0;
            for (int p = 0; p < NRD; p++) raddr[p] = AW'($urandom_range(0, NREGS - 1));
            if ($urandom_range(0, 2) == 0) raddr[0] = waddr;
            #2;
            for (int p = 0; p < NRD; p++) chk($sformatf("rnd%0d_rd%0d", c, p), rdata[p], m_read(p, raddr[p]));
            exp_err = we && !m_accept();
            if (m_accept()) m_mem[waddr] = wdata;
            if (clr_req) m_clear();
            else if (m_busy > 0) m_busy--;
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_wr_err", c), 32'(wr_err), 32'(exp_err));
            chk($sformatf("rnd%0d_ready", c), 32'(ready), 32'(m_busy == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-instance 15+PC register file of the datapath: NREGS x DW storage, NRD combinational read ports, one write port.
- Top index always reads the external PC input.
- Adds an active-low asynchronous reset, a hardware clear sweep, same-cycle write-through bypass, and a write-error flag.
- Trailing "extended" read ports are gated by a mode input, as the multiply/divide operands are today.
- Sits between decode and the ALU/divider in the processor datapath.

Parameters:
- DW, 32, data width of every register and port.
- NREGS, 16, number of architectural indices; index NREGS-1 is the PC alias and has no storage.
- NRD, 4, number of read ports.
- NEXT, 2, number of trailing read ports (NRD-NEXT..NRD-1) gated by ext_en; legal range 0..NRD.
- AW, $clog2(NREGS), derived localparam, address width; not overridable.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  request a full clear sweep; sampled on posedge.
- we  in  1  write enable.
- waddr  in  AW  write index.
- wdata  in  DW  write data.
- pc_in  in  DW  current PC; returned for reads of index NREGS-1.
- ext_en  in  1  enables extended ports; low forces them to constant 1.
- raddr  in  NRD x AW  read indices, packed array.
- rdata  out  NRD x DW  read data, packed array, combinational.
- ready  out  1  high when in RUN; registered.
- wr_err  out  1  one-cycle registered pulse flagging an illegal or dropped write.

Behaviour:
- Reset (rst_n=0, async):
  - state=INIT, sweep counter=0, ready=0, wr_err=0.
  - Storage is not reset directly; it is zeroed by the sweep.
- States:
  - INIT: each cycle writes 0 to storage[cnt] and increments cnt. When cnt==NREGS-2, next state is RUN. The sweep therefore takes NREGS-1 cycles after rst_n deasserts, and ready rises on the following edge.
  - RUN: ready=1. clr_req=1 -> INIT with cnt=0; ready drops on the same edge.
  - clr_req in INIT restarts the sweep at cnt=0.
  - rst_n asserted mid-sweep restarts the sweep asynchronously.
- Write, accepted only when all hold: state==RUN, we=1, waddr!=NREGS-1, clr_req=0. Accepted write: storage[waddr]<=wdata on posedge.
- wr_err<=1 on the next edge when we=1 and any of: waddr==NREGS-1, state==INIT, or clr_req=1. Otherwise wr_err<=0. A rejected write never modifies storage.
- waddr>=NREGS (non-power-of-two NREGS): the write is ignored and wr_err pulses.
- Read port i, evaluated in priority order:
  1. Extended port (i>=NRD-NEXT) with ext_en=0 -> DW'(1).
  2. raddr[i]==NREGS-1 -> pc_in.
  3. state==INIT -> 0.
  4. Accepted write this cycle with waddr==raddr[i] -> wdata (bypass).
  5. Out-of-range index -> 0.
  6. Otherwise storage[raddr[i]].
- Latency: reads are 0 cycles (combinational); writes are visible through storage 1 cycle later, and in the same cycle through the bypass.
- All read ports are independent; any number of them may read the same index at once.

Decomposition:
- Package regfile_pkg:
  - typedef enum logic {INIT, RUN} rf_state_t.
  - localparam DW_DEFAULT=32, NREGS_DEFAULT=16.
  - localparam logic [31:0] EXT_IDLE_VAL=1.
- One natural sub-module, regfile_clear_fsm: owns state, cnt, ready; outputs clr_we and clr_addr. The top-level storage is written from either the sweep or the accepted-write path.

Test Plan:
- Release rst_n, ext_en=1, raddr all 0: rdata=0 and ready=0 for cycles 0..14; ready=1 at cycle 15 (NREGS=16).
- RUN, write waddr=3 wdata=32'hDEADBEEF with raddr[0]=3 in the same cycle -> rdata[0]=DEADBEEF that cycle (bypass) and the next cycle from storage; wr_err stays 0.
- raddr[1]=15, pc_in=32'h0000_0100 -> rdata[1]=00000100; then write waddr=15 -> wr_err pulses one cycle, rdata[1] still follows pc_in.
- ext_en=0 with raddr[2]=3, raddr[3]=3 -> rdata[2]=rdata[3]=1 while rdata[0] (raddr[0]=3) =DEADBEEF; ext_en=1 -> both DEADBEEF.
- RUN, assert clr_req for one cycle with we=1 waddr=5 -> wr_err=1, ready=0, reg 5 unchanged (0), all regs read 0 after the sweep, ready back after 15 cycles.
- Assert rst_n=0 mid-sweep at cnt=7 -> ready stays 0; the full 15-cycle sweep restarts after release.
